// File: rtl/nxd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nxd_timer : KS-10 bus-cycle watchdog. Ends unacknowledged IO/memory cycles |
// |             and raises sticky NXD/NXM flags with the failing address.      |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module nxd_timer #(
  parameter int TIMEOUT    = 64,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iolatch,
  input  logic                  busIO,
  input  logic [ADDR_WIDTH-1:0] busADDR,
  input  logic                  busACK,
  input  logic                  clrERR,
  output logic                  cpuWAIT,
  output logic                  cycDONE,
  output logic                  nxd,
  output logic                  nxm,
  output logic                  nxdINT,
  output logic [ADDR_WIDTH-1:0] errADDR
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_ACKED = 2'd2;
  localparam logic [1:0] c_TOUT  = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [c_CNT_W-1:0]    count_q,    count_d;
  logic                  iol_prev_q, iol_prev_d;
  logic                  cyc_io_q,   cyc_io_d;
  logic [ADDR_WIDTH-1:0] cyc_addr_q, cyc_addr_d;
  logic                  nxd_q,      nxd_d;
  logic                  nxm_q,      nxm_d;
  logic                  nxd_int_q,  nxd_int_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  w_start;
  logic                  w_tout_entry;

  assign w_start = iolatch & ~iol_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort on a dropped latch outranks an ack, which outranks the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_start) state_d = c_WAIT;
      end
      c_WAIT: begin
        if (!iolatch)               state_d = c_IDLE;
        else if (busACK)            state_d = c_ACKED;
        else if (count_q == c_LIMIT) state_d = c_TOUT;
      end
      c_ACKED, c_TOUT: begin
        if (!iolatch) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    cpuWAIT = (state_q == c_WAIT);
    cycDONE = (state_q == c_ACKED) || (state_q == c_TOUT);
    nxd     = nxd_q;
    nxm     = nxm_q;
    nxdINT  = nxd_int_q;
    errADDR = err_addr_q;
  end

  always_comb begin
    iol_prev_d   = iolatch;
    count_d      = count_q;
    cyc_io_d     = cyc_io_q;
    cyc_addr_d   = cyc_addr_q;
    nxd_d        = nxd_q;
    nxm_d        = nxm_q;
    err_addr_d   = err_addr_q;
    w_tout_entry = (state_q == c_WAIT) && (state_d == c_TOUT);
    nxd_int_d    = w_tout_entry;

    if ((state_q == c_IDLE) && w_start) begin
      count_d    = '0;
      cyc_io_d   = busIO;
      cyc_addr_d = busADDR;
    end else if ((state_q == c_WAIT) && (state_d == c_WAIT)) begin
      count_d = count_q + c_CNT_W'(1);
    end

    if (clrERR) begin
      nxd_d      = 1'b0;
      nxm_d      = 1'b0;
      err_addr_d = '0;
    end

    // A new error beats a simultaneous clear; otherwise the first error keeps its address.
    if (w_tout_entry) begin
      if (cyc_io_q) nxd_d = 1'b1;
      else          nxm_d = 1'b1;
      if (clrERR || (!nxd_q && !nxm_q)) err_addr_d = cyc_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      iol_prev_q <= 1'b0;
      cyc_io_q   <= 1'b0;
      cyc_addr_q <= '0;
      nxd_q      <= 1'b0;
      nxm_q      <= 1'b0;
      nxd_int_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      count_q    <= count_d;
      iol_prev_q <= iol_prev_d;
      cyc_io_q   <= cyc_io_d;
      cyc_addr_q <= cyc_addr_d;
      nxd_q      <= nxd_d;
      nxm_q      <= nxm_d;
      nxd_int_q  <= nxd_int_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nxd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nxd_timer : directed self-checking bench for the bus-cycle watchdog.    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_nxd_timer;

  localparam int c_TO = 64;
  localparam int c_AW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            iolatch = 1'b0;
  logic            busIO = 1'b0;
  logic [c_AW-1:0] busADDR = '0;
  logic            busACK = 1'b0;
  logic            clrERR = 1'b0;
  logic            cpuWAIT, cycDONE, nxd, nxm, nxdINT;
  logic [c_AW-1:0] errADDR;

  int n_total = 0;
  int n_bad   = 0;
  int waits, ints, int_at;

  nxd_timer #(.TIMEOUT(c_TO), .ADDR_WIDTH(c_AW)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .iolatch (iolatch),
    .busIO   (busIO),
    .busADDR (busADDR),
    .busACK  (busACK),
    .clrERR  (clrERR),
    .cpuWAIT (cpuWAIT),
    .cycDONE (cycDONE),
    .nxd     (nxd),
    .nxm     (nxm),
    .nxdINT  (nxdINT),
    .errADDR (errADDR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a cycle, then drive ack / drop / clear on chosen edges after the start edge.
  task automatic run_cycle(input logic io, input logic [c_AW-1:0] addr, input int ack_at,
                           input int drop_at, input int clr_at,
                           output int w, output int p, output int p_at);
    busIO = io; busADDR = addr; busACK = 1'b0; clrERR = 1'b0; iolatch = 1'b1;
    tick();
    w = int'(cpuWAIT); p = 0; p_at = -1;
    for (int n = 1; n <= c_TO + 2; n++) begin
      busACK = (n == ack_at);
      clrERR = (n == clr_at);
      if (n == drop_at) iolatch = 1'b0;
      tick();
      if (cpuWAIT) w++;
      if (nxdINT) begin
        p++;
        if (p_at < 0) p_at = n;
      end
    end
    busACK = 1'b0; clrERR = 1'b0;
  endtask

  task automatic end_cycle(input string tag);
    iolatch = 1'b0; busACK = 1'b0;
    tick();
    chk({tag, "_idle_done"}, 32'(cycDONE), 0);
    chk({tag, "_idle_wait"}, 32'(cpuWAIT), 0);
  endtask

  task automatic clear_err();
    clrERR = 1'b1;
    tick();
    clrERR = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_wait", 32'(cpuWAIT), 0);
    chk("rst_done", 32'(cycDONE), 0);
    chk("rst_nxd",  32'(nxd), 0);
    chk("rst_nxm",  32'(nxm), 0);
    chk("rst_int",  32'(nxdINT), 0);
    chk("rst_addr", 32'(errADDR), 0);
    tick();
    rst = 1'b0;
    tick();

    // Acked IO cycle, ack on the 5th edge.
    run_cycle(1'b1, 20'h12345, 5, 0, 0, waits, ints, int_at);
    chk("ack_waits", 32'(waits), 5);
    chk("ack_ints",  32'(ints), 0);
    chk("ack_done",  32'(cycDONE), 1);
    chk("ack_cpuw",  32'(cpuWAIT), 0);
    chk("ack_nxd",   32'(nxd), 0);
    chk("ack_nxm",   32'(nxm), 0);
    end_cycle("ack");

    // IO timeout.
    run_cycle(1'b1, 20'h3A010, 0, 0, 0, waits, ints, int_at);
    chk("tio_waits", 32'(waits), 64);
    chk("tio_ints",  32'(ints), 1);
    chk("tio_int_at", int_at, 64);
    chk("tio_done",  32'(cycDONE), 1);
    chk("tio_nxd",   32'(nxd), 1);
    chk("tio_nxm",   32'(nxm), 0);
    chk("tio_addr",  32'(errADDR), 32'h3A010);
    end_cycle("tio");
    chk("tio_nxd_sticky", 32'(nxd), 1);
    clear_err();
    chk("clr1_nxd",  32'(nxd), 0);
    chk("clr1_addr", 32'(errADDR), 0);

    // Memory timeout, then a second IO timeout that must not overwrite errADDR.
    run_cycle(1'b0, 20'h01234, 0, 0, 0, waits, ints, int_at);
    chk("tmem_nxm",  32'(nxm), 1);
    chk("tmem_nxd",  32'(nxd), 0);
    chk("tmem_addr", 32'(errADDR), 32'h01234);
    end_cycle("tmem");
    run_cycle(1'b1, 20'h3FFFF, 0, 0, 0, waits, ints, int_at);
    chk("t2_ints", 32'(ints), 1);
    chk("t2_nxd",  32'(nxd), 1);
    chk("t2_nxm",  32'(nxm), 1);
    chk("t2_addr", 32'(errADDR), 32'h01234);
    end_cycle("t2");
    clear_err();
    chk("clr2_nxd",  32'(nxd), 0);
    chk("clr2_nxm",  32'(nxm), 0);
    chk("clr2_addr", 32'(errADDR), 0);

    // Ack on the limit edge wins over the timeout.
    run_cycle(1'b1, 20'h00ABC, 64, 0, 0, waits, ints, int_at);
    chk("acklim_waits", 32'(waits), 64);
    chk("acklim_ints",  32'(ints), 0);
    chk("acklim_done",  32'(cycDONE), 1);
    chk("acklim_nxd",   32'(nxd), 0);
    end_cycle("acklim");

    // Clear on the timeout edge: the set wins.
    run_cycle(1'b1, 20'h22222, 0, 0, 64, waits, ints, int_at);
    chk("clrlim_ints", 32'(ints), 1);
    chk("clrlim_nxd",  32'(nxd), 1);
    chk("clrlim_addr", 32'(errADDR), 32'h22222);
    end_cycle("clrlim");

    // Latch dropped on edge 30: abort, no new flag or strobe.
    run_cycle(1'b0, 20'h05555, 0, 30, 0, waits, ints, int_at);
    chk("drop_waits", 32'(waits), 30);
    chk("drop_ints",  32'(ints), 0);
    chk("drop_done",  32'(cycDONE), 0);
    chk("drop_nxm",   32'(nxm), 0);
    chk("drop_nxd",   32'(nxd), 1);
    chk("drop_addr",  32'(errADDR), 32'h22222);

    // Asynchronous reset at count 40, released with the latch held high.
    busIO = 1'b1; busADDR = 20'h07777; iolatch = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) tick();
    chk("pre_rst_wait", 32'(cpuWAIT), 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_wait", 32'(cpuWAIT), 0);
    chk("mrst_done", 32'(cycDONE), 0);
    chk("mrst_nxd",  32'(nxd), 0);
    chk("mrst_addr", 32'(errADDR), 0);
    busIO = 1'b0; busADDR = 20'h0F0F0;
    tick();
    rst = 1'b0;
    tick();
    chk("rel_start", 32'(cpuWAIT), 1);
    waits = 1; ints = 0;
    for (int n = 1; n <= c_TO + 2; n++) begin
      tick();
      if (cpuWAIT) waits++;
      if (nxdINT) ints++;
    end
    chk("rel_waits", 32'(waits), 64);
    chk("rel_ints",  32'(ints), 1);
    chk("rel_nxm",   32'(nxm), 1);
    chk("rel_addr",  32'(errADDR), 32'h0F0F0);
    end_cycle("rel");

    // Retrigger: held latch in ACKED is ignored; restart two clocks after the fall.
    run_cycle(1'b1, 20'h00042, 3, 0, 0, waits, ints, int_at);
    chk("rt_waits", 32'(waits), 3);
    for (int i = 0; i < 3; i++) begin
      busACK = ~busACK;
      tick();
    end
    busACK = 1'b0;
    chk("rt_held_done", 32'(cycDONE), 1);
    chk("rt_held_wait", 32'(cpuWAIT), 0);
    iolatch = 1'b0;
    tick();
    chk("rt_fall_done", 32'(cycDONE), 0);
    tick();
    iolatch = 1'b1;
    tick();
    chk("rt_restart", 32'(cpuWAIT), 1);
    end_cycle("rt");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
